mpram_nrd_bypass: RTL
=====================

Name: mpram_nrd_bypass

Overview:
- Parametrised successor to the team's single-write, dual-read BRAM wrapper with write-first bypass.
- Generalises to NRD read ports, per-lane (per-LLR) write enables, selectable collision mode (write-first / read-first) and an optional output register stage.
- Adds per-port read-valid strobes.
- Stores the partial-sum/LLR vectors of the SC decoder: 2^p lanes of Q bits each, at depth 2^(n-p)-2+p.

Parameters:
- n, 5, code length exponent (N = 2^n).
- p, 1, parallelism exponent; the word holds 2^p lanes.
- Q, 6, bits per lane.
- NRD, 2, number of read ports (1..8).
- MODE, 0, collision mode: 0 = write-first, 1 = read-first.
- OUT_REG, 0, 1 inserts an extra output register; read latency becomes 2.
- Derived: LANES = 2^p; DATA_WIDTH = LANES*Q; DEPTH = 2^(n-p)-2+p; ADDR_WIDTH = $clog2(DEPTH).

Ports:
- clk, in, 1, single clock; all logic on the rising edge.
- rst_n, in, 1, synchronous active-low reset.
- we, in, 1, write request.
- wlane, in, LANES, per-lane write mask; lane k = din[k*Q +: Q].
- wr_addr, in, ADDR_WIDTH, write address.
- din, in, DATA_WIDTH, write data.
- re, in, NRD, per-port read request.
- rd_addr, in, NRD*ADDR_WIDTH, port i address = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH].
- dout, out, NRD*DATA_WIDTH, port i data = dout[i*DATA_WIDTH +: DATA_WIDTH].
- rvalid, out, NRD, port i data is valid this cycle.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All pipeline registers, dout and rvalid become 0.
  - Memory array is not cleared; it retains its contents.
  - we is ignored while rst_n is low.
  - Reads in flight when reset is asserted are dropped; no rvalid is issued for them.
- Storage:
  - DEPTH x DATA_WIDTH array, inferred as block RAM.
  - One write port and NRD synchronous read ports. Replicate the array per read port if required; every replica receives an identical write.
- Write:
  - Commits at the edge where we=1 and wr_addr < DEPTH.
  - Only lanes with wlane[k]=1 are updated; other lanes keep their old values.
  - we=1 with wlane=0 is a no-op.
  - wr_addr >= DEPTH: write is ignored.
- Read latency L = 1 + OUT_REG cycles from the edge sampling re[i]=1 to rvalid[i]=1 with dout valid.
  - rvalid[i] is a pure delay of re[i] by L cycles, reset to 0.
- Hold: when no read completes on port i in a cycle, dout[i] holds its last value (rvalid low).
- Out-of-range read (rd_addr_i >= DEPTH): returns all-zero data, with rvalid asserted normally.
- Collision (same edge: we=1, re[i]=1, wr_addr == rd_addr_i):
  - MODE=0 (write-first): lanes with wlane=1 return the new din lane; other lanes return the stored old value.
    - Implement by registering din, wlane and a per-port hit flag, then merging with the RAM output one cycle later.
    - Do not rely on the RAM primitive's collision behaviour; gate the RAM read enable during a collision, as the predecessor did.
  - MODE=1 (read-first): returns the pre-write contents for all lanes.
- Multiple ports may read the same address in the same cycle; each port resolves its collision independently.
- A write in cycle t+1 to an address read in cycle t never affects that read's data, including when OUT_REG=1.
- Back-to-back operation:
  - Full throughput: a read may issue every cycle on every port.
  - Write then read of the same address in the next cycle returns the written data (normal RAM path).
- OUT_REG=1: the second stage loads only when the delayed re is 1; otherwise it holds.
- Widths: no arithmetic. The address compare is an ADDR_WIDTH-bit equality, valid only when both addresses are < DEPTH.

Test Plan (defaults: DATA_WIDTH=12, DEPTH=15, ADDR_WIDTH=4, NRD=2):
- Reset, then re=2'b11, rd_addr={4'd1,4'd0} -> dout=0 and rvalid=0 until after reset; 1 cycle after the read, rvalid=2'b11.
- Write we=1, wlane=2'b11, addr 3, din=12'hABC; next cycle read port 0 addr 3 -> one cycle later dout0=12'hABC, rvalid[0]=1.
- MODE=0 collision:
  - Preload addr 5 = 12'h123.
  - Same cycle: we=1, wlane=2'b10, din=12'hFC0, addr 5, and read port 1 addr 5 -> dout1=12'hFE3 (lane1 new, lane0 old).
  - Next read of addr 5 -> 12'hFE3.
- MODE=1 collision, same stimulus -> dout1=12'h123 at the collision; subsequent read -> 12'hFE3.
- OUT_REG=1: reads issued on 4 consecutive cycles on both ports -> rvalid high on 4 consecutive cycles starting 2 cycles later, data in order. A collision on the 2nd read returns the merged value at its slot.
- Reset asserted mid-stream:
  - rst_n=0 for one cycle with 2 reads in flight -> no rvalid for those reads; dout=0.
  - Memory contents preserved: addr 3 still reads 12'hABC.
  - Write with we=1 during reset -> not committed.
  - Read of addr 15 -> 12'h000 with rvalid=1.

Source files
------------

// File: rtl/mpram_nrd_bypass.sv
// Multi-port LLR/partial-sum RAM: one lane-masked write port, NRD synchronous read ports,
// selectable write-first/read-first collision handling and an optional output register.
module mpram_nrd_bypass #(
    parameter int unsigned n       = 5,
    parameter int unsigned p       = 1,
    parameter int unsigned Q       = 6,
    parameter int unsigned NRD     = 2,
    parameter int unsigned MODE    = 0,
    parameter int unsigned OUT_REG = 0,
    localparam int unsigned LANES      = 2 ** p,
    localparam int unsigned DATA_WIDTH = LANES * Q,
    localparam int unsigned DEPTH      = 2 ** (n - p) - 2 + p,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we,
    input  logic [LANES-1:0]            wlane,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic [NRD-1:0]              re,
    input  logic [NRD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NRD*DATA_WIDTH-1:0]   dout,
    output logic [NRD-1:0]              rvalid
);

    logic wr_en;
    logic wr_full;

    assign wr_en   = we && rst_n && (32'(wr_addr) < DEPTH);
    assign wr_full = &wlane;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [ADDR_WIDTH-1:0] ra;
        logic                  ra_ok;
        logic                  hit;
        logic                  ram_en;
        logic [DATA_WIDTH-1:0] ram_q;
        logic [DATA_WIDTH-1:0] din_q;
        logic [LANES-1:0]      lane_q;
        logic                  hit_q;
        logic                  oor_q;
        logic                  rv1;
        logic [DATA_WIDTH-1:0] merged_c;

        assign ra    = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign ra_ok = 32'(ra) < DEPTH;
        assign hit   = (MODE == 0) && wr_en && re[i] && ra_ok && (ra == wr_addr);
        // RAM data is only needed for lanes the colliding write leaves untouched
        assign ram_en = re[i] && ra_ok && !(hit && wr_full);

        // Replica write: every port's copy sees the identical lane-masked write
        always_ff @(posedge clk) begin
            if (wr_en) begin
                for (int k = 0; k < LANES; k++) begin
                    if (wlane[k]) begin
                        mem[wr_addr][k*Q +: Q] <= din[k*Q +: Q];
                    end
                end
            end
        end

        // First read stage: RAM output plus bypass context, loaded only on a read
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ram_q  <= '0;
                din_q  <= '0;
                lane_q <= '0;
                hit_q  <= 1'b0;
                oor_q  <= 1'b0;
                rv1    <= 1'b0;
            end else begin
                rv1 <= re[i];
                if (re[i]) begin
                    din_q  <= din;
                    lane_q <= wlane;
                    hit_q  <= hit;
                    oor_q  <= !ra_ok;
                end
                if (ram_en) begin
                    ram_q <= mem[ra];
                end
            end
        end

        always_comb begin
            merged_c = ram_q;
            if (hit_q) begin
                for (int k = 0; k < LANES; k++) begin
                    if (lane_q[k]) begin
                        merged_c[k*Q +: Q] = din_q[k*Q +: Q];
                    end
                end
            end
            if (oor_q) begin
                merged_c = '0;
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] dq;
            logic                  rv2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dq  <= '0;
                    rv2 <= 1'b0;
                end else begin
                    rv2 <= rv1;
                    if (rv1) begin
                        dq <= merged_c;
                    end
                end
            end

            assign dout[i*DATA_WIDTH +: DATA_WIDTH] = dq;
            assign rvalid[i]                        = rv2;
        end else begin : g_direct
            assign dout[i*DATA_WIDTH +: DATA_WIDTH] = merged_c;
            assign rvalid[i]                        = rv1;
        end
    end

endmodule
